cafe_ctrl_multi: RTL and testbench
==================================

# cafe_ctrl_multi

Parametrised next-generation coffee-machine controller: user selects one of N_DRINKS recipes, the block checks the water/cup sensor, accumulates coin credit against a per-drink price table, then sequences pressurisation, heating and dispense. All durations come from internal cycle timers, not external timer strobes. Credit is refunded on cancel or payment timeout. The block sits between the front-panel buttons/coin acceptor and the valve/heater drivers and LED decoder.

## Interface
- N_DRINKS, 4: number of recipes (2..8)
- CREDIT_W, 8: credit/price/coin width
- PRICES, 32'h28_1E_19_14: packed price table; drink i price = PRICES[i*CREDIT_W +: CREDIT_W] (defaults 20, 25, 30, 40)
- T_SELECT, 1000: SELECT and PAY inactivity timeout, cycles
- T_PRESS, 200: pressurisation duration, cycles
- T_HEAT, 500: heat duration unit; drink i heats T_HEAT*(i+1) cycles
- T_DONE, 300: DONE hold, cycles
- T_ERR, 300: ERR hold, cycles
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- BOTAO_CONFIRMA  in  1  confirm button, one-cycle pulse
- BOTAO_PROXIMO  in  1  next-drink pulse
- BOTAO_CANCELA  in  1  cancel pulse
- SENSOR  in  2  bit1 reading valid, bit0 fault
- COIN_VALID  in  1  coin strobe
- COIN_VALUE  in  CREDIT_W  coin value, qualified by COIN_VALID
- SAIDA  out  4  current state code
- SEL  out  $clog2(N_DRINKS)  selected drink
- CREDIT  out  CREDIT_W  accumulated credit
- CHANGE_VALID  out  1  one-cycle refund/change strobe
- CHANGE_AMT  out  CREDIT_W  amount, qualified by CHANGE_VALID
- VALVE, HEATER  out  1  actuator enables

## Operation
- States/codes: IDLE 0, SELECT 1, CHECK 2, PAY 3, ERR 4, PRESS 5, HEAT 6, DONE 7.
- IDLE: CONFIRMA → SELECT, SEL=0.
- SELECT: PROXIMO increments SEL, wrapping N_DRINKS-1→0, reloads timer; CONFIRMA → CHECK; timeout → IDLE. CONFIRMA and PROXIMO together: CONFIRMA wins, SEL unchanged.
- CHECK: SENSOR=10 → PAY; SENSOR=11 → IDLE; 00/01 wait.
- PAY: COIN_VALID adds COIN_VALUE to CREDIT, saturating at 2^CREDIT_W-1, reloads timer. CREDIT ≥ price(SEL) → PRESS. Timeout with CREDIT=0 → IDLE; with CREDIT>0 → ERR.
- ERR: refund full CREDIT on entry, clear CREDIT, hold T_ERR cycles → IDLE.
- CANCELA in SELECT/CHECK/PAY → IDLE, refunding CREDIT if nonzero. Coin and cancel in the same cycle: coin included in refund.
- PRESS: VALVE=1, T_PRESS cycles → HEAT. HEAT: VALVE=1, HEATER=1, T_HEAT*(SEL+1) cycles → DONE. PRESS/HEAT/DONE ignore buttons and coins.
- DONE: price deducted on entry; excess handling per Configuration; T_DONE cycles → IDLE, CREDIT=0.
- Arithmetic: timer width sized for max(T_HEAT*N_DRINKS, T_SELECT, …); credit compare unsigned.

## Timing
- Reset: SAIDA=0, SEL=0, CREDIT=0, CHANGE_VALID=0, CHANGE_AMT=0, VALVE=0, HEATER=0, timer=0. Reset mid-brew drops actuators immediately; credit is lost.
- All outputs registered; transitions on the rising CLK after the qualifying input.
- Timed states last exactly T cycles: timer loads T-1 on entry, exits the cycle after it reads 0.
- Coin that reaches price: CREDIT updates and SAIDA=PRESS on the same edge.
- CHANGE_VALID high exactly one cycle, the first cycle of the target state.

## Configuration
- CAFE_TROCO_EN defined: on DONE entry, if CREDIT > price, CHANGE_VALID pulses with CHANGE_AMT = CREDIT − price.
- Undefined: excess credit is absorbed, no strobe on DONE. Cancel/ERR refunds are unaffected.

## Structure
- Package cafe_pkg: state codes, state enum, price-extract function, timer width function.
- Sub-module cafe_timer: loadable down-counter with zero flag; one instance shared by all timed states.

## Test plan
- Defaults, SEL=2, SENSOR=10, coins 10,10,10 → PRESS after third coin, CREDIT=30; HEAT lasts 1500 cycles; IDLE after DONE.
- With CAFE_TROCO_EN, SEL=0, coin 25 → DONE entry CHANGE_VALID=1, CHANGE_AMT=5; without it, no strobe.
- PAY, coin 10, then no input for T_SELECT cycles → ERR, CHANGE_AMT=10, IDLE after 300 cycles.
- SELECT, PROXIMO ×5 with N_DRINKS=4 → SEL=1; CONFIRMA+PROXIMO same cycle → CHECK, SEL=1.
- CHECK with SENSOR=11 → IDLE, no strobe; PAY with coin 10 and CANCELA in the same cycle as coin 5 → IDLE, CHANGE_AMT=15.
- RST_N low during HEAT → VALVE=HEATER=0 asynchronously, SAIDA=0, CREDIT=0.

Source files
------------

// File: rtl/cafe_pkg.sv
// Shared definitions for the coffee-machine controller: state codes, the
// matching state enum, the price-table lookup and the timer sizing rule.
package cafe_pkg;

  // State codes as presented on SAIDA.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SELECT = 4'd1;
  localparam logic [3:0] ST_CHECK  = 4'd2;
  localparam logic [3:0] ST_PAY    = 4'd3;
  localparam logic [3:0] ST_ERR    = 4'd4;
  localparam logic [3:0] ST_PRESS  = 4'd5;
  localparam logic [3:0] ST_HEAT   = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_SELECT = ST_SELECT,
    S_CHECK  = ST_CHECK,
    S_PAY    = ST_PAY,
    S_ERR    = ST_ERR,
    S_PRESS  = ST_PRESS,
    S_HEAT   = ST_HEAT,
    S_DONE   = ST_DONE
  } cafe_state_e;

  // Widest price table accepted: 8 drinks of up to 32-bit prices.
  localparam int unsigned PRICE_TBL_W = 256;

  // Extract entry idx (each w bits wide) from a packed price table.
  function automatic logic [31:0] price_at(input logic [PRICE_TBL_W-1:0] tbl,
                                           input int unsigned idx,
                                           input int unsigned w);
    logic [PRICE_TBL_W-1:0] sh;
    logic [PRICE_TBL_W-1:0] mask;
    sh   = tbl >> (idx * w);
    mask = (PRICE_TBL_W'(1) << w) - PRICE_TBL_W'(1);
    return 32'(sh & mask);
  endfunction

  // Bits needed to hold the largest duration any timed state can load.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d,
                                              input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cafe_timer.sv
// Loadable down-counter with a zero flag. Load wins over counting; the
// counter parks at zero until the next load.
module cafe_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on request, otherwise decrement towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cafe_ctrl_multi.sv
// Multi-recipe coffee-machine controller: drink selection, sensor check,
// coin payment with refunds, then timed pressurise/heat/dispense.
// Optional feature: define CAFE_TROCO_EN to return excess credit as change
// on DONE entry; without it the excess is absorbed.
// Change output: CHANGE_VALID is a one-cycle strobe qualifying CHANGE_AMT;
// there is no back-pressure, the consumer must take it in that cycle.
module cafe_ctrl_multi
  import cafe_pkg::*;
#(
  parameter int                          N_DRINKS = 4,
  parameter int                          CREDIT_W = 8,
  parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES  = 32'h28_1E_19_14,
  parameter int                          T_SELECT = 1000,
  parameter int                          T_PRESS  = 200,
  parameter int                          T_HEAT   = 500,
  parameter int                          T_DONE   = 300,
  parameter int                          T_ERR    = 300
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        BOTAO_CONFIRMA,
  input  logic                        BOTAO_PROXIMO,
  input  logic                        BOTAO_CANCELA,
  input  logic [1:0]                  SENSOR,
  input  logic                        COIN_VALID,
  input  logic [CREDIT_W-1:0]         COIN_VALUE,
  output logic [3:0]                  SAIDA,
  output logic [$clog2(N_DRINKS)-1:0] SEL,
  output logic [CREDIT_W-1:0]         CREDIT,
  output logic                        CHANGE_VALID,
  output logic [CREDIT_W-1:0]         CHANGE_AMT,
  output logic                        VALVE,
  output logic                        HEATER
);

  localparam int SW = $clog2(N_DRINKS);
  localparam int unsigned TW = timer_width(T_HEAT * N_DRINKS, T_SELECT, T_PRESS, T_DONE, T_ERR);

  logic [3:0]          state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                chg_v_q, chg_v_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic                valve_q, heater_q;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_zero;

  logic [CREDIT_W-1:0] price_sel;
  logic [CREDIT_W:0]   sum_w;
  logic [CREDIT_W-1:0] coin_sum;
  logic [CREDIT_W-1:0] refund;

  assign price_sel = CREDIT_W'(price_at(PRICE_TBL_W'(PRICES), 32'(sel_q), CREDIT_W));
  assign sum_w     = {1'b0, credit_q} + {1'b0, COIN_VALUE};
  assign coin_sum  = sum_w[CREDIT_W] ? '1 : sum_w[CREDIT_W-1:0];
  // A coin arriving with cancel is part of what gets handed back.
  assign refund    = COIN_VALID ? coin_sum : credit_q;

  cafe_timer #(.W(TW)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, selection, credit, change and timer-load decisions.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    credit_d  = credit_q;
    chg_v_d   = 1'b0;
    chg_amt_d = '0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        if (BOTAO_CONFIRMA) begin
          state_d  = ST_SELECT;
          sel_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SELECT - 1);
        end
      end
      ST_SELECT: begin
        if (BOTAO_CANCELA) begin
          state_d = ST_IDLE;
        end else if (BOTAO_CONFIRMA) begin
          state_d = ST_CHECK;
        end else if (BOTAO_PROXIMO) begin
          sel_d    = (sel_q == SW'(N_DRINKS - 1)) ? '0 : sel_q + SW'(1);
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SELECT - 1);
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (BOTAO_CANCELA) begin
          state_d = ST_IDLE;
        end else if (SENSOR == 2'b10) begin
          state_d  = ST_PAY;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SELECT - 1);
        end else if (SENSOR == 2'b11) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (BOTAO_CANCELA) begin
          state_d  = ST_IDLE;
          credit_d = '0;
          if (refund != '0) begin
            chg_v_d   = 1'b1;
            chg_amt_d = refund;
          end
        end else if (COIN_VALID) begin
          credit_d = coin_sum;
          tmr_load = 1'b1;
          if (coin_sum >= price_sel) begin
            state_d = ST_PRESS;
            tmr_val = TW'(T_PRESS - 1);
          end else begin
            tmr_val = TW'(T_SELECT - 1);
          end
        end else if (credit_q >= price_sel) begin
          state_d  = ST_PRESS;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_PRESS - 1);
        end else if (tmr_zero) begin
          if (credit_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_ERR;
            chg_v_d   = 1'b1;
            chg_amt_d = credit_q;
            credit_d  = '0;
            tmr_load  = 1'b1;
            tmr_val   = TW'(T_ERR - 1);
          end
        end
      end
      ST_ERR: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      ST_PRESS: begin
        if (tmr_zero) begin
          state_d  = ST_HEAT;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_HEAT) * (TW'(sel_q) + TW'(1)) - TW'(1);
        end
      end
      ST_HEAT: begin
        if (tmr_zero) begin
          state_d  = ST_DONE;
          credit_d = credit_q - price_sel;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_DONE - 1);
`ifdef CAFE_TROCO_EN
          if (credit_q > price_sel) begin
            chg_v_d   = 1'b1;
            chg_amt_d = credit_q - price_sel;
          end
`endif
        end
      end
      ST_DONE: begin
        if (tmr_zero) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Registered state and outputs; actuators follow the state being entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      credit_q  <= '0;
      chg_v_q   <= 1'b0;
      chg_amt_q <= '0;
      valve_q   <= 1'b0;
      heater_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      credit_q  <= credit_d;
      chg_v_q   <= chg_v_d;
      chg_amt_q <= chg_amt_d;
      valve_q   <= (state_d == ST_PRESS) || (state_d == ST_HEAT);
      heater_q  <= (state_d == ST_HEAT);
    end
  end

  assign SAIDA        = state_q;
  assign SEL          = sel_q;
  assign CREDIT       = credit_q;
  assign CHANGE_VALID = chg_v_q;
  assign CHANGE_AMT   = chg_amt_q;
  assign VALVE        = valve_q;
  assign HEATER       = heater_q;

endmodule

// File: tb/tb_cafe_ctrl_multi.sv
// Bench for cafe_ctrl_multi. Follows CAFE_TROCO_EN the same way the design
// does, so it can be compiled with or without the macro.
module tb_cafe_ctrl_multi;

  localparam int N_DRINKS = 4;
  localparam int T_SELECT = 1000;
  localparam int T_PRESS  = 200;
  localparam int T_HEAT   = 500;
  localparam int T_DONE   = 300;
  localparam int T_ERR    = 300;

  localparam int S_IDLE = 0, S_SELECT = 1, S_CHECK = 2, S_PAY = 3;
  localparam int S_ERR = 4, S_PRESS = 5, S_HEAT = 6, S_DONE = 7;

  int price_tab[4] = '{20, 25, 30, 40};

  logic       CLK, RST_N;
  logic       BOTAO_CONFIRMA, BOTAO_PROXIMO, BOTAO_CANCELA;
  logic [1:0] SENSOR;
  logic       COIN_VALID;
  logic [7:0] COIN_VALUE;
  logic [3:0] SAIDA;
  logic [1:0] SEL;
  logic [7:0] CREDIT;
  logic       CHANGE_VALID;
  logic [7:0] CHANGE_AMT;
  logic       VALVE, HEATER;

  // Expected change strobes: {state at strobe, amount}.
  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  cafe_ctrl_multi #(
    .N_DRINKS(N_DRINKS), .CREDIT_W(8), .PRICES(32'h28_1E_19_14),
    .T_SELECT(T_SELECT), .T_PRESS(T_PRESS), .T_HEAT(T_HEAT),
    .T_DONE(T_DONE), .T_ERR(T_ERR)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .BOTAO_CONFIRMA(BOTAO_CONFIRMA), .BOTAO_PROXIMO(BOTAO_PROXIMO),
    .BOTAO_CANCELA(BOTAO_CANCELA), .SENSOR(SENSOR),
    .COIN_VALID(COIN_VALID), .COIN_VALUE(COIN_VALUE),
    .SAIDA(SAIDA), .SEL(SEL), .CREDIT(CREDIT),
    .CHANGE_VALID(CHANGE_VALID), .CHANGE_AMT(CHANGE_AMT),
    .VALVE(VALVE), .HEATER(HEATER)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [11:0] mk(input int st, input int amt);
    logic [11:0] r;
    r = {st[3:0], amt[7:0]};
    return r;
  endfunction

  function automatic int sat8(input int a);
    return (a > 255) ? 255 : a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic btn(input bit c, input bit p, input bit x);
    BOTAO_CONFIRMA = c;
    BOTAO_PROXIMO  = p;
    BOTAO_CANCELA  = x;
    cycle();
    BOTAO_CONFIRMA = 1'b0;
    BOTAO_PROXIMO  = 1'b0;
    BOTAO_CANCELA  = 1'b0;
  endtask

  task automatic coin(input int v, input bit with_cancel);
    COIN_VALID    = 1'b1;
    COIN_VALUE    = 8'(v);
    BOTAO_CANCELA = with_cancel;
    cycle();
    COIN_VALID    = 1'b0;
    COIN_VALUE    = 8'd0;
    BOTAO_CANCELA = 1'b0;
  endtask

  // Cycles spent in state st from now, bounded by max.
  task automatic measure(input int st, input int max, output int n);
    n = 0;
    while (int'(SAIDA) == st && n < max) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_select(input int nprox);
    btn(1, 0, 0);
    chk("select_entry", int'(SAIDA), S_SELECT);
    chk("select_sel0", int'(SEL), 0);
    repeat (nprox) btn(0, 1, 0);
    chk("select_sel", int'(SEL), nprox % N_DRINKS);
    btn(1, 0, 0);
    chk("check_entry", int'(SAIDA), S_CHECK);
  endtask

  task automatic do_check_pass();
    int k;
    k = $urandom_range(0, 3);
    repeat (k) begin
      SENSOR = 2'($urandom_range(0, 1));
      cycle();
    end
    chk("check_wait", int'(SAIDA), S_CHECK);
    SENSOR = 2'b10;
    cycle();
    SENSOR = 2'b00;
    chk("pay_entry", int'(SAIDA), S_PAY);
  endtask

  // Brew sequence after payment reached price; credit is the paid amount.
  task automatic brew(input int sel, input int credit);
    int n, price;
    price = price_tab[sel];
    chk("press_valve", int'(VALVE), 1);
    chk("press_heater", int'(HEATER), 0);
    measure(S_PRESS, T_PRESS + 10, n);
    chk("press_len", n, T_PRESS);
    chk("heat_state", int'(SAIDA), S_HEAT);
    chk("heat_valve", int'(VALVE), 1);
    chk("heat_heater", int'(HEATER), 1);
`ifdef CAFE_TROCO_EN
    if (credit > price) exp_q.push_back(mk(S_DONE, credit - price));
`endif
    measure(S_HEAT, T_HEAT * N_DRINKS + 10, n);
    chk("heat_len", n, T_HEAT * (sel + 1));
    chk("done_state", int'(SAIDA), S_DONE);
    chk("done_credit", int'(CREDIT), credit - price);
    chk("done_valve", int'(VALVE), 0);
    chk("done_heater", int'(HEATER), 0);
    measure(S_DONE, T_DONE + 10, n);
    chk("done_len", n, T_DONE);
    chk("after_done_state", int'(SAIDA), S_IDLE);
    chk("after_done_credit", int'(CREDIT), 0);
  endtask

  task automatic pay_full(input int sel);
    int credit, v;
    credit = 0;
    while (credit < price_tab[sel]) begin
      idle($urandom_range(0, 10));
      chk("pay_hold", int'(SAIDA), S_PAY);
      v = ($urandom_range(0, 4) == 0) ? 250 : $urandom_range(1, 15);
      credit = sat8(credit + v);
      coin(v, 1'b0);
      chk("pay_credit", int'(CREDIT), credit);
      chk("pay_state", int'(SAIDA), (credit >= price_tab[sel]) ? S_PRESS : S_PAY);
    end
    brew(sel, credit);
  endtask

  task automatic pay_cancel();
    int credit, v, nc;
    bit with_coin;
    credit = 0;
    nc = $urandom_range(0, 3);
    repeat (nc) begin
      v = $urandom_range(1, 5);
      credit += v;
      coin(v, 1'b0);
      chk("cancel_pre_credit", int'(CREDIT), credit);
    end
    with_coin = 1'($urandom_range(0, 1));
    v = with_coin ? $urandom_range(1, 5) : 0;
    if (credit + v > 0) exp_q.push_back(mk(S_IDLE, credit + v));
    if (with_coin) coin(v, 1'b1);
    else           btn(0, 0, 1);
    chk("cancel_state", int'(SAIDA), S_IDLE);
    chk("cancel_credit", int'(CREDIT), 0);
  endtask

  task automatic pay_timeout();
    int credit, v, nc, n;
    credit = 0;
    nc = $urandom_range(0, 2);
    repeat (nc) begin
      v = $urandom_range(1, 5);
      credit += v;
      coin(v, 1'b0);
    end
    if (credit > 0) exp_q.push_back(mk(S_ERR, credit));
    measure(S_PAY, T_SELECT + 10, n);
    chk("pay_timeout_len", n, T_SELECT);
    if (credit > 0) begin
      chk("err_state", int'(SAIDA), S_ERR);
      chk("err_credit", int'(CREDIT), 0);
      measure(S_ERR, T_ERR + 10, n);
      chk("err_len", n, T_ERR);
    end
    chk("timeout_idle", int'(SAIDA), S_IDLE);
  endtask

  task automatic session();
    int nprox, sel, mode;
    nprox = $urandom_range(0, 6);
    sel   = nprox % N_DRINKS;
    mode  = $urandom_range(0, 3);
    do_select(nprox);
    if (mode == 3) begin
      SENSOR = 2'b11;
      cycle();
      SENSOR = 2'b00;
      chk("sensor_fault_idle", int'(SAIDA), S_IDLE);
    end else begin
      do_check_pass();
      case (mode)
        0:       pay_full(sel);
        1:       pay_cancel();
        default: pay_timeout();
      endcase
    end
    idle($urandom_range(1, 4));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (RST_N && CHANGE_VALID) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL change_unexpected: got state=%0d amt=%0d, required no strobe (t=%0t)",
                 SAIDA, CHANGE_AMT, $time);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({SAIDA, CHANGE_AMT} !== e) begin
          n_bad++;
          $display("FAIL change_strobe: got state=%0d amt=%0d, required state=%0d amt=%0d (t=%0t)",
                   SAIDA, CHANGE_AMT, e[11:8], e[7:0], $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    RST_N = 1'b0;
    BOTAO_CONFIRMA = 1'b0; BOTAO_PROXIMO = 1'b0; BOTAO_CANCELA = 1'b0;
    SENSOR = 2'b00; COIN_VALID = 1'b0; COIN_VALUE = 8'd0;
    #23;
    chk("rst_saida", int'(SAIDA), 0);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_credit", int'(CREDIT), 0);
    chk("rst_chg_valid", int'(CHANGE_VALID), 0);
    chk("rst_chg_amt", int'(CHANGE_AMT), 0);
    chk("rst_valve", int'(VALVE), 0);
    chk("rst_heater", int'(HEATER), 0);
    RST_N = 1'b1;
    cycle();
    chk("idle_after_rst", int'(SAIDA), S_IDLE);

    // Drink 2 paid with 10+10+10.
    do_select(2);
    do_check_pass();
    coin(10, 1'b0);
    chk("d2_c1", int'(CREDIT), 10);
    idle(3);
    coin(10, 1'b0);
    chk("d2_c2_state", int'(SAIDA), S_PAY);
    coin(10, 1'b0);
    chk("d2_c3_state", int'(SAIDA), S_PRESS);
    chk("d2_c3_credit", int'(CREDIT), 30);
    brew(2, 30);

    // Drink 0 overpaid with a single 25 coin.
    do_select(0);
    do_check_pass();
    coin(25, 1'b0);
    chk("d0_state", int'(SAIDA), S_PRESS);
    chk("d0_credit", int'(CREDIT), 25);
    brew(0, 25);

    // Payment timeout with credit 10 goes through ERR.
    do_select(1);
    do_check_pass();
    coin(10, 1'b0);
    exp_q.push_back(mk(S_ERR, 10));
    measure(S_PAY, T_SELECT + 10, n);
    chk("err10_pay_len", n, T_SELECT);
    chk("err10_state", int'(SAIDA), S_ERR);
    measure(S_ERR, T_ERR + 10, n);
    chk("err10_len", n, T_ERR);
    chk("err10_idle", int'(SAIDA), S_IDLE);

    // Selection wrap and confirm/next collision, then sensor fault.
    btn(1, 0, 0);
    repeat (5) btn(0, 1, 0);
    chk("wrap_sel", int'(SEL), 1);
    btn(1, 1, 0);
    chk("collide_state", int'(SAIDA), S_CHECK);
    chk("collide_sel", int'(SEL), 1);
    SENSOR = 2'b01;
    cycle();
    chk("sensor01_wait", int'(SAIDA), S_CHECK);
    SENSOR = 2'b11;
    cycle();
    SENSOR = 2'b00;
    chk("sensor11_idle", int'(SAIDA), S_IDLE);

    // Cancel together with a coin refunds both coins.
    do_select(3);
    do_check_pass();
    coin(10, 1'b0);
    exp_q.push_back(mk(S_IDLE, 15));
    coin(5, 1'b1);
    chk("cancel15_state", int'(SAIDA), S_IDLE);
    chk("cancel15_credit", int'(CREDIT), 0);

    // Selection inactivity timeout.
    btn(1, 0, 0);
    measure(S_SELECT, T_SELECT + 10, n);
    chk("select_timeout_len", n, T_SELECT);
    chk("select_timeout_idle", int'(SAIDA), S_IDLE);

    // Randomised sessions.
    for (int i = 0; i < 16; i++) session();

    // Reset during HEAT drops actuators without waiting for a clock.
    do_select(3);
    do_check_pass();
    coin(250, 1'b0);
    chk("rst_test_press", int'(SAIDA), S_PRESS);
    measure(S_PRESS, T_PRESS + 10, n);
    idle(100);
    chk("rst_test_heat", int'(SAIDA), S_HEAT);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_valve", int'(VALVE), 0);
    chk("midrst_heater", int'(HEATER), 0);
    chk("midrst_saida", int'(SAIDA), 0);
    chk("midrst_credit", int'(CREDIT), 0);
    idle(2);
    RST_N = 1'b1;
    idle(2);
    chk("post_rst_idle", int'(SAIDA), S_IDLE);

    idle(5);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
